piso_tx: RTL and testbench
==========================

Name: piso_tx

Overview:
- Parallel-in serial-out transmitter. It is the transmit-side counterpart of the team's 4-bit SIPO shift-register receiver.
- Accepts a WIDTH-bit word on a valid/ready handshake and shifts it out one bit per clock.
- sout_valid frames the serial stream, and a done pulse marks the final bit.
- With MSB_FIRST=1, sout feeds the SIPO input directly, and the SIPO parallel output reproduces the transmitted word.

Parameters:
WIDTH, 4, data word width in bits; legal range is 2 to 32.
MSB_FIRST, 1, 1 = din[WIDTH-1] is sent first; 0 = din[0] is sent first.

Ports:
clk  in  1  clock; all state changes on posedge
rst  in  1  synchronous active-high reset
din  in  WIDTH  parallel word to transmit
load_valid  in  1  din is valid
load_ready  out  1  block can accept a word this cycle
sout  out  1  serial data out, registered
sout_valid  out  1  sout carries a data or parity bit, registered
done  out  1  one-cycle pulse, coincident with the last serial bit

Behaviour:
- Reset is synchronous and active-high; clock is clk, reset is rst.
  - On a posedge with rst=1: state=IDLE, shift reg=0, bit counter=0, sout=0, sout_valid=0, done=0.
  - load_valid is ignored on any edge where rst=1.
- States:
  - IDLE: nothing in flight.
  - SHIFT: bits being sent.
  - PAR: parity bit being sent; exists only with the optional feature.
- load_ready (combinational) is 1 in either case:
  - state is IDLE;
  - the current cycle carries the final serial bit (done=1 this cycle).
- Otherwise load_ready is 0. It is 1 while rst is held, with no effect.
- Accept = load_valid & load_ready at posedge.
  - Capture din into the shift reg, set counter=0, go to SHIFT.
  - Latency: the first bit appears on sout the cycle after accept.
- In SHIFT, bit k (k = 0..WIDTH-1) is presented in cycle k+1 after accept, with sout_valid=1.
  - The shift reg shifts toward the output end each cycle.
  - Counter width is $clog2(WIDTH+1).
- On the final bit cycle, done=1.
  - If accept also occurs on that edge, the next word's first bit follows with no gap. sout_valid stays 1 and state stays SHIFT.
  - Otherwise the next state is IDLE, with sout=0 and sout_valid=0.
- din and load_valid are don't-care while load_ready=0. No stall; the source holds valid until ready.
- Reset mid-word aborts the word:
  - no done pulse;
  - the next cycle shows sout=0, sout_valid=0, load_ready=1.
- sout is forced to 0 whenever sout_valid=0.

Optional Feature:
- Macro PISO_PARITY_EN.
- Defined:
  - After the WIDTH data bits, one PAR cycle sends the even-parity bit (XOR of the word) with sout_valid=1.
  - done and the load_ready window move to the PAR cycle, making a frame WIDTH+1 cycles.
- Undefined:
  - The PAR state and parity logic are absent, and a frame is WIDTH cycles.
  - Serial output is then bit-compatible with the SIPO receiver.

Decomposition:
- Package piso_pkg holds:
  - state encoding constants IDLE, SHIFT, PAR;
  - default WIDTH;
  - counter-width function/localparam.
- One natural sub-module: piso_bit_cnt, a loadable up-counter with a terminal-count flag that drives done and load_ready.
- The shift register stays inline.

Test Plan:
1. Reset, then load 4'b1011 (MSB_FIRST=1):
   - sout = 1,0,1,1 in cycles 1-4 with sout_valid=1;
   - done only in cycle 4;
   - load_ready=0 in cycles 1-3, 1 from cycle 4.
2. Back-to-back 4'hA then 4'h5, load_valid held high:
   - 8 contiguous bits 1,0,1,0,0,1,0,1 with no sout_valid gap;
   - done pulses in cycles 4 and 8.
3. Loopback: sout drives a 4-bit SIPO on the same clk/rst, send 4'hB:
   - in the cycle after done, SIPO d == 4'hB.
4. Load 4'hF, assert rst during cycle 2:
   - next cycle sout=0, sout_valid=0, load_ready=1;
   - no done pulse follows.
5. MSB_FIRST=0, load 4'b0001:
   - sout = 1,0,0,0;
   - load_valid held while busy causes no second accept until cycle 4.
6. With PISO_PARITY_EN, load 4'b1011:
   - sout = 1,0,1,1,1 (parity=1) over 5 cycles;
   - done in cycle 5.
   - With 4'b0110, the parity bit is 0.

Source files
------------

// File: rtl/piso_pkg.sv
// Purpose: shared types and sizing helpers for the piso_tx serial transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a. Holds the FSM state encoding, the default word width and the
// bit-counter width function used by piso_tx and piso_bit_cnt.
package piso_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

    // Counter must be able to hold WIDTH, so it needs clog2(WIDTH+1) bits.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/piso_bit_cnt.sv
// Purpose: loadable up-counter of serial bit positions with a terminal-count flag.
// Latency: load/increment take effect on the next posedge; tc is combinational from the count.
// Backpressure: none; counts whenever en is high.
// Ports: clk, rst (sync, active-high), load (clear to 0), en (increment),
//        tc (count equals WIDTH-1, i.e. the final data bit is on the line).
module piso_bit_cnt #(
    parameter int WIDTH = 4,
    parameter int CW    = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic tc
);

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tc = (cnt == LAST);

endmodule

// File: rtl/piso_tx.sv
// Purpose: parallel-in serial-out transmitter, one bit per clk, framed by sout_valid.
// Latency: first bit on sout the cycle after accept; done coincides with the final bit.
// Backpressure: load_ready only in IDLE or on the final-bit cycle; no stall once a word starts.
// Ports: clk, rst (sync, active-high), din[WIDTH], load_valid/load_ready handshake,
//        sout/sout_valid (registered serial stream), done (pulse on last serial bit).
// Build option: define PISO_PARITY_EN to append an even-parity bit (PAR state) to each frame.
module piso_tx
    import piso_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             done
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             sout_q, sout_d;
    logic             vld_q, vld_d;
    logic             cnt_load, cnt_en;
    logic             last_data;
    logic             done_int;
    logic             accept;
    logic [WIDTH-1:0] shreg_shifted;
    logic             next_bit;
    logic             first_bit;
`ifdef PISO_PARITY_EN
    logic             par_q, par_d;
`endif

    piso_bit_cnt #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_bit_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (cnt_load),
        .en   (cnt_en),
        .tc   (last_data)
    );

    // The bit currently on sout sits at the output end of shreg_q; the
    // next bit to send is its neighbour one position inward.
    assign shreg_shifted = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                     : {1'b0, shreg_q[WIDTH-1:1]};
    assign next_bit      = MSB_FIRST ? shreg_q[WIDTH-2] : shreg_q[1];
    assign first_bit     = MSB_FIRST ? din[WIDTH-1] : din[0];

`ifdef PISO_PARITY_EN
    assign done_int = (state_q == PAR);
`else
    assign done_int = (state_q == SHIFT) && last_data;
`endif

    // A word aborted by reset never signals done.
    assign done       = done_int & ~rst;
    assign load_ready = rst | (state_q == IDLE) | done_int;
    assign accept     = load_valid & load_ready & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        sout_d   = 1'b0;
        vld_d    = 1'b0;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
`ifdef PISO_PARITY_EN
        par_d    = par_q;
`endif
        case (state_q)
            SHIFT: begin
                if (!last_data) begin
                    shreg_d = shreg_shifted;
                    sout_d  = next_bit;
                    vld_d   = 1'b1;
                    cnt_en  = 1'b1;
                end else begin
`ifdef PISO_PARITY_EN
                    state_d = PAR;
                    sout_d  = par_q;
                    vld_d   = 1'b1;
`else
                    state_d = IDLE;
`endif
                end
            end
`ifdef PISO_PARITY_EN
            PAR: begin
                state_d = IDLE;
            end
`endif
            default: begin
                state_d = state_q;
            end
        endcase

        // Accept overrides the end-of-frame return to IDLE so a new word
        // follows the final bit with no gap.
        if (accept) begin
            state_d  = SHIFT;
            shreg_d  = din;
            sout_d   = first_bit;
            vld_d    = 1'b1;
            cnt_load = 1'b1;
`ifdef PISO_PARITY_EN
            par_d    = ^din;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
            sout_q  <= 1'b0;
            vld_q   <= 1'b0;
`ifdef PISO_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            shreg_q <= shreg_d;
            sout_q  <= sout_d;
            vld_q   <= vld_d;
`ifdef PISO_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign sout       = sout_q;
    assign sout_valid = vld_q;

endmodule

// File: tb/tb_piso_tx.sv
// Purpose: self-checking bench for piso_tx (MSB-first and LSB-first instances plus a SIPO loopback).
// Latency: expectations come from a per-instance queue of pending serial bits.
// Backpressure: sources hold load_valid until the reference model says the word was taken.
module tb_piso_tx;

`ifdef PISO_PARITY_EN
    localparam int FR = 5;
`else
    localparam int FR = 4;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] din_a = '0, din_b = '0;
    logic       lv_a = 1'b0, lv_b = 1'b0;
    logic       rdy_a, rdy_b, sout_a, sout_b, sv_a, sv_b, done_a, done_b;
    logic [3:0] sipo_d;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: bits still to appear on each serial line, in order.
    bit         q_a[$];
    bit         q_b[$];
    logic [3:0] words_a[$];
    bit         acc_a, acc_b;
    bit         sipo_pend = 0;
    logic [3:0] sipo_word = '0;

    always #5 clk = ~clk;

    piso_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .rst(rst), .din(din_a), .load_valid(lv_a), .load_ready(rdy_a),
        .sout(sout_a), .sout_valid(sv_a), .done(done_a)
    );

    piso_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .rst(rst), .din(din_b), .load_valid(lv_b), .load_ready(rdy_b),
        .sout(sout_b), .sout_valid(sv_b), .done(done_b)
    );

    // 4-bit SIPO receiver fed by the MSB-first transmitter.
    always_ff @(posedge clk) begin
        if (rst) sipo_d <= '0;
        else     sipo_d <= {sipo_d[2:0], sout_a};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Serial order of one frame: data bits then (optionally) even parity.
    function automatic logic [4:0] frame_bits(input logic [3:0] w, input bit msb);
        logic [4:0] f;
        f = '0;
        for (int k = 0; k < 4; k++) f[k] = msb ? w[3-k] : w[k];
        f[4] = ^w;
        return f;
    endfunction

    task automatic step();
        bit         e_rdy_a, e_rdy_b;
        logic [4:0] fa, fb;
        @(negedge clk);
        e_rdy_a = rst || (q_a.size() <= 1);
        e_rdy_b = rst || (q_b.size() <= 1);
        chk("a.sout_valid", 32'(sv_a), 32'(q_a.size() > 0));
        chk("a.sout", 32'(sout_a), (q_a.size() > 0) ? 32'(q_a[0]) : 32'd0);
        chk("a.done", 32'(done_a), 32'(!rst && q_a.size() == 1));
        chk("a.load_ready", 32'(rdy_a), 32'(e_rdy_a));
        chk("b.sout_valid", 32'(sv_b), 32'(q_b.size() > 0));
        chk("b.sout", 32'(sout_b), (q_b.size() > 0) ? 32'(q_b[0]) : 32'd0);
        chk("b.done", 32'(done_b), 32'(!rst && q_b.size() == 1));
        chk("b.load_ready", 32'(rdy_b), 32'(e_rdy_b));
`ifndef PISO_PARITY_EN
        if (sipo_pend) chk("sipo.loopback", 32'(sipo_d), 32'(sipo_word));
        sipo_pend = 0;
        if (!rst && q_a.size() == 1 && words_a.size() > 0) begin
            sipo_pend = 1;
            sipo_word = words_a.pop_front();
        end
`endif
        acc_a = !rst && lv_a && e_rdy_a;
        acc_b = !rst && lv_b && e_rdy_b;
        fa = frame_bits(din_a, 1'b1);
        fb = frame_bits(din_b, 1'b0);
        @(posedge clk);
        if (rst) begin
            q_a.delete();
            q_b.delete();
            words_a.delete();
            sipo_pend = 0;
        end else begin
            if (q_a.size() > 0) void'(q_a.pop_front());
            if (q_b.size() > 0) void'(q_b.pop_front());
            if (acc_a) begin
                for (int k = 0; k < FR; k++) q_a.push_back(fa[k]);
                words_a.push_back(din_a);
            end
            if (acc_b) for (int k = 0; k < FR; k++) q_b.push_back(fb[k]);
        end
        #1;
    endtask

    task automatic send_a(input logic [3:0] w);
        bit got = 0;
        lv_a = 1'b1;
        din_a = w;
        for (int i = 0; i < 16 && !got; i++) begin
            step();
            got = acc_a;
        end
        if (!got) chk("a.accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_b(input logic [3:0] w);
        bit got = 0;
        lv_b = 1'b1;
        din_b = w;
        for (int i = 0; i < 16 && !got; i++) begin
            step();
            got = acc_b;
        end
        if (!got) chk("b.accept_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        // Reset: held over two edges, then checked as one step with rst still high.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        step();
        rst = 1'b0;
        step();

        // Single word 1011, then idle (loopback check lands after done).
        send_a(4'b1011);
        lv_a = 1'b0;
        repeat (6) step();

        // Back-to-back A then 5 with load_valid held.
        send_a(4'hA);
        send_a(4'h5);
        lv_a = 1'b0;
        repeat (6) step();

        // Reset during the second bit of 4'hF.
        send_a(4'hF);
        lv_a = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (6) step();

        // LSB-first: 0001 then another word with valid held while busy.
        send_b(4'b0001);
        send_b(4'h6);
        lv_b = 1'b0;
        repeat (6) step();

        // Words with odd and even parity.
        send_a(4'b1011);
        send_a(4'b0110);
        lv_a = 1'b0;
        repeat (6) step();

        // Random traffic with occasional resets.
        for (int n = 0; n < 300; n++) begin
            lv_a  = 1'($urandom_range(0, 1));
            lv_b  = 1'($urandom_range(0, 1));
            din_a = 4'($urandom);
            din_b = 4'($urandom);
            rst   = ($urandom_range(0, 40) == 0);
            step();
        end
        rst = 1'b0;
        lv_a = 1'b0;
        lv_b = 1'b0;
        repeat (8) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
